// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences a WIDTH-bit add through one external 4-bit adder, LSB nibble first
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_reset_b,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic [WIDTH-1:0] i_b_in,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum_out,
   output logic             o_cout_out,
   output logic             o_overflow,
   output logic [3:0]       o_add_a,
   output logic [3:0]       o_add_b,
   output logic             o_add_c0,
   input  logic [3:0]       i_add_sum,
   input  logic             i_add_c4
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_cin, r_cout, r_ovf;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic             w_run, w_last;
   assign w_run  = r_state == RUN;
   assign w_last = r_idx == IW'(NIBBLES - 1);
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = i_start ? RUN : IDLE;
         RUN:     w_state_nxt = i_abort ? IDLE : (w_last ? DONE : RUN);
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clock or negedge i_reset_b) begin
      if (!i_reset_b)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end
   // abort suppresses the nibble write so cout/overflow can never load on a cancelled add
   always_ff @(posedge i_clock or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cin   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == IDLE && i_start) begin
         r_a    <= i_a_in;
         r_b    <= i_b_in;
         r_cin  <= i_cin;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_idx  <= '0;
      end else if (w_run && !i_abort) begin
         r_sum[4*r_idx +: 4] <= i_add_sum;
         r_carry             <= i_add_c4;
         r_idx               <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_cout <= i_add_c4;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (i_add_sum[3] != r_a[WIDTH-1]);
         end
      end else if (w_run) begin
         r_idx <= '0;
      end
   end
   assign o_add_a    = w_run ? r_a[4*r_idx +: 4] : 4'd0;
   assign o_add_b    = w_run ? r_b[4*r_idx +: 4] : 4'd0;
   assign o_add_c0   = w_run ? ((r_idx == '0) ? r_cin : r_carry) : 1'b0;
   assign o_busy     = w_run;
   assign o_done     = r_state == DONE;
   assign o_sum_out  = r_sum;
   assign o_cout_out = r_cout;
   assign o_overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed vectors for WIDTH=16 and WIDTH=4 with a behavioural 4-bit adder
module tb_nibble_serial_add_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, cin = 1'b0;
   logic [15:0] a_in = '0, b_in = '0, sum;
   logic        busy, done, cout, ovf, add_c0, add_c4;
   logic [3:0]  add_a, add_b, add_sum;
   logic        start4 = 1'b0, cin4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0, sum4, add_a4, add_b4, add_sum4;
   logic        busy4, done4, cout4, ovf4, add_c04, add_c44;
   int          n_vec = 0, n_bad = 0, done_cnt = 0, cnt;

   always #5 clk = ~clk;

   assign {add_c4, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_c0);
   assign {add_c44, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_c04);

   nibble_serial_add_ctrl #(.WIDTH(16)) u_dut (
      .i_clock(clk), .i_reset_b(rst_n), .i_start(start), .i_abort(abort),
      .i_a_in(a_in), .i_b_in(b_in), .i_cin(cin),
      .o_busy(busy), .o_done(done), .o_sum_out(sum), .o_cout_out(cout), .o_overflow(ovf),
      .o_add_a(add_a), .o_add_b(add_b), .o_add_c0(add_c0),
      .i_add_sum(add_sum), .i_add_c4(add_c4));

   nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
      .i_clock(clk), .i_reset_b(rst_n), .i_start(start4), .i_abort(1'b0),
      .i_a_in(a4), .i_b_in(b4), .i_cin(cin4),
      .o_busy(busy4), .o_done(done4), .o_sum_out(sum4), .o_cout_out(cout4), .o_overflow(ovf4),
      .o_add_a(add_a4), .o_add_b(add_b4), .o_add_c0(add_c04),
      .i_add_sum(add_sum4), .i_add_c4(add_c44));

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
      @(negedge clk);
      a_in = a; b_in = b; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic full_add(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [15:0] es, input logic ec, input logic eo);
      int n;
      start_op(a, b, c);
      wait_done(n);
      check({tag, "_lat"}, n, 4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout_ovf", {cout, ovf}, 0);
      check("rst_adder_in", {add_a, add_b, add_c0}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      start_op(16'h1234, 16'h4321, 1'b0);
      check("run_busy", busy, 1);
      check("run_add_in", {add_a, add_b, add_c0}, {4'h4, 4'h1, 1'b0});
      wait_done(cnt);
      check("basic_lat", cnt, 4);
      check("basic_sum", sum, 16'h5555);
      check("basic_co", {cout, ovf}, 0);
      @(negedge clk);
      check("idle_quiet", {add_a, add_b, add_c0, busy}, 0);
      check("hold_sum", sum, 16'h5555);

      full_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      full_add("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      full_add("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      full_add("cin", 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);

      done_cnt = 0;
      start_op(16'h1234, 16'h4321, 1'b0);
      a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("ign_sum", sum, 16'h5555);
      check("ign_done_cnt", done_cnt, 1);

      done_cnt = 0;
      start_op(16'hFFFF, 16'h0001, 1'b0);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("abort_done_cnt", done_cnt, 0);
      check("abort_co", {cout, ovf}, 0);

      done_cnt = 0;
      start_op(16'h1234, 16'h4321, 1'b0);
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy_done", {busy, done}, 0);
      check("arst_sum", sum, 0);
      check("arst_adder_in", {add_a, add_b, add_c0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("arst_done_cnt", done_cnt, 0);

      @(negedge clk);
      a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      cnt = 0;
      while (!done4 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("w4_lat", cnt, 1);
      check("w4_sum", sum4, 4'h2);
      check("w4_cout_ovf", {cout4, ovf4}, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
